// File: rtl/sin_amp_gen_pkg.sv
// Shared constants and the quarter-wave table generator for sin_amp_gen.
// The table is built at elaboration time with integer arithmetic only.
package sin_amp_gen_pkg;

    localparam int M     = 12;
    localparam int NS    = 2 ** M;
    localparam int PW    = 16;
    localparam int LUT_N = 65;

    // pi scaled by 2**30; the sine series below works in that fixed-point format
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(2**M * sin(2*pi*k/256)) for k = 0..64 via a Taylor series in Q30
    function automatic logic [M:0] qlut_val(input int k);
        longint x;
        longint x2;
        longint t;
        longint s;
        x  = (PI_Q30 * longint'(k)) / 128;
        x2 = (x * x) >>> 30;
        t  = x;
        s  = x;
        for (int n = 1; n <= 10; n++) begin
            t = -((t * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return (M + 1)'((s * (longint'(1) << M) + (longint'(1) << 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sin_amp_gen_if.sv
// Host-side control and sample-stream signals of the sine test source.
interface sin_amp_gen_if;
    import sin_amp_gen_pkg::*;

    logic          ce;
    logic          we;
    logic [M-1:0]  AMP;
    logic [PW-1:0] DPH;
    logic          ce_tact;
    logic          ce_zero;
    logic [M:0]    SIN;
    logic [M-1:0]  AMP_R;

    modport master (
        output ce, we, AMP, DPH,
        input  ce_tact, ce_zero, SIN, AMP_R
    );

    modport slave (
        input  ce, we, AMP, DPH,
        output ce_tact, ce_zero, SIN, AMP_R
    );

endinterface

// File: rtl/sin_amp_gen_qlut.sv
// Combinational quarter-wave sine ROM: 65 entries of round(2**M*sin(2*pi*k/256)).
module sin_amp_gen_qlut
    import sin_amp_gen_pkg::*;
(
    input  logic [6:0] idx,
    output logic [M:0] data
);

    logic [M:0] rom [0:LUT_N-1];

    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam logic [M:0] VAL = qlut_val(k);
        assign rom[k] = VAL;
    end

    // NOTE: data gets a default before the conditional so no path leaves it unassigned (no latch).
    always_comb begin
        data = '0;
        if (idx <= 7'(LUT_N - 1)) begin
            data = rom[idx];
        end
    end

endmodule

// File: rtl/sin_amp_gen.sv
// Programmable-amplitude offset-binary sine source: phase accumulator,
// quadrant fold, three-stage ce-gated multiply/round/offset pipeline.
module sin_amp_gen
    import sin_amp_gen_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    sin_amp_gen_if.slave bus
);

    localparam logic [M:0]   MID = (M + 1)'(NS);
    localparam logic [2*M:0] RND = (2 * M + 1)'(2 ** (M - 1));

    logic [PW-1:0] ph;
    logic [PW-1:0] dph_r;
    logic [M-1:0]  amp_r;
    logic          ph_start;
    logic [PW:0]   ph_sum;
    logic          carry;
    logic          load;

    assign ph_sum      = {1'b0, ph} + {1'b0, dph_r};
    assign carry       = ph_sum[PW];
    assign bus.ce_tact = bus.ce & carry;
    // an idle block (zero step) accepts a load at once, otherwise only on a wrap
    assign load        = bus.ce & bus.we & (carry | (dph_r == '0));

    // NOTE: registered state is always written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= '0;
            dph_r    <= '0;
            amp_r    <= '0;
            ph_start <= 1'b0;
        end else if (bus.ce) begin
            ph_start <= load | carry;
            if (load) begin
                ph    <= '0;
                amp_r <= bus.AMP;
                dph_r <= bus.DPH;
            end else begin
                ph <= ph_sum[PW-1:0];
            end
        end
    end

    logic [7:0] p;
    logic [6:0] lut_idx;
    logic [M:0] lut_data;

    assign p       = ph[PW-1 -: 8];
    assign lut_idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};

    sin_amp_gen_qlut u_qlut (
        .idx  (lut_idx),
        .data (lut_data)
    );

    logic [M:0]   l_s1;
    logic         neg_s1;
    logic         zero_s1;
    logic [M:0]   y_s2;
    logic         neg_s2;
    logic         zero_s2;
    logic [2*M:0] prod;
    logic [2*M:0] prod_rnd;
    logic [M:0]   sin_r;
    logic         zero_r;

    assign prod     = amp_r * l_s1;
    assign prod_rnd = prod + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_s1    <= '0;
            neg_s1  <= 1'b0;
            zero_s1 <= 1'b0;
            y_s2    <= '0;
            neg_s2  <= 1'b0;
            zero_s2 <= 1'b0;
            sin_r   <= MID;
            zero_r  <= 1'b0;
        end else if (bus.ce) begin
            l_s1    <= lut_data;
            neg_s1  <= p[7];
            zero_s1 <= ph_start;
            y_s2    <= prod_rnd[2*M:M];
            neg_s2  <= neg_s1;
            zero_s2 <= zero_s1;
            // y never exceeds amp_r, so neither branch can leave the code range
            sin_r   <= neg_s2 ? (MID - y_s2) : (MID + y_s2);
            zero_r  <= zero_s2;
        end
    end

    assign bus.SIN     = sin_r;
    assign bus.ce_zero = zero_r;
    assign bus.AMP_R   = amp_r;

endmodule

// File: tb/tb_sin_amp_gen.sv
// Scoreboard bench for sin_amp_gen: the driver runs a sample-history model and
// queues expectations; a negedge monitor pops and compares against the DUT.
module tb_sin_amp_gen;

    localparam int M  = 12;
    localparam int PW = 16;
    localparam int NS = 4096;
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        int sin;
        bit zero;
        int amp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sin_amp_gen_if bus ();

    sin_amp_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   pend_out = 1'b0;
    exp_t q_out[$];
    bit   q_tact[$];

    int   m_ph, m_amp, m_dph;
    bit   m_start;
    int   h_ph[$];
    int   h_amp[$];
    bit   h_start[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lut(input int k);
        return $rtoi($floor(4096.0 * $sin(2.0 * PI * real'(k) / 256.0) + 0.5));
    endfunction

    // Sample value for phase ph scaled by amplitude amp, straight from the angle rules.
    function automatic int sample(input int amp, input int ph);
        int p, q, i, k, y;
        p = ph / 256;
        q = p / 64;
        i = p % 64;
        k = (q % 2 == 1) ? 64 - i : i;
        y = (amp * lut(k) + 2048) / 4096;
        return (q >= 2) ? NS - y : NS + y;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_amp = 0; m_dph = 0; m_start = 1'b0;
        h_ph = '{0, 0}; h_amp = '{0, 0}; h_start = '{1'b0, 1'b0};
        q_out.delete();
        q_tact.delete();
    endtask

    // One clock: drive inputs, advance the model on ce ticks, wait to just after the edge.
    task automatic tick(input bit c, input bit w, input int amp, input int dph);
        bit   carry, load;
        exp_t e;
        bus.ce  = c;
        bus.we  = w;
        bus.AMP = amp[M-1:0];
        bus.DPH = dph[PW-1:0];
        if (c) begin
            carry = (m_ph + m_dph) >= (1 << PW);
            load  = w && (carry || m_dph == 0);
            q_tact.push_back(carry);
            h_ph.push_back(m_ph);
            h_amp.push_back(m_amp);
            h_start.push_back(m_start);
            e.sin  = sample(h_amp[1], h_ph[0]);
            e.zero = h_start[0];
            if (load) begin
                m_ph = 0; m_amp = amp; m_dph = dph; m_start = 1'b1;
            end else begin
                m_ph = (m_ph + m_dph) % (1 << PW); m_start = carry;
            end
            e.amp = m_amp;
            q_out.push_back(e);
            void'(h_ph.pop_front());
            void'(h_amp.pop_front());
            void'(h_start.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   t;
        if (!mon_en) begin
            pend_out = 1'b0;
        end else begin
            if (pend_out) begin
                if (q_out.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL q_out: DUT produced a sample with nothing expected");
                end else begin
                    e = q_out.pop_front();
                    check("SIN", int'(bus.SIN), e.sin);
                    check("ce_zero", int'(bus.ce_zero), int'(e.zero));
                    check("AMP_R", int'(bus.AMP_R), e.amp);
                end
            end
            pend_out = bus.ce;
            if (bus.ce) begin
                if (q_tact.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL q_tact: ce tick with nothing expected");
                end else begin
                    t = q_tact.pop_front();
                    check("ce_tact", int'(bus.ce_tact), int'(t));
                end
            end
        end
    end

    // Load 1000 / 0x400 from idle and check the quarter-period landmarks.
    task automatic run_plan();
        int plan[4];
        plan = '{4096, 5096, 4096, 3096};
        tick(1'b1, 1'b1, 1000, 'h400);
        for (int j = 1; j <= 140; j++) begin
            tick(1'b1, 1'b0, $urandom_range(0, 4095), $urandom_range(0, 65535));
            if (j >= 3 && j < 67 && (j - 3) % 16 == 0)
                check("plan_sin", int'(bus.SIN), plan[(j - 3) / 16]);
            if (j == 3)
                check("plan_zero", int'(bus.ce_zero), 1);
        end
    endtask

    task automatic track(input int n, output int mx, output int mn);
        mx = 0; mn = 1 << 30;
        for (int j = 0; j < n; j++) begin
            tick(1'b1, 1'b0, 0, 0);
            if (int'(bus.SIN) > mx) mx = int'(bus.SIN);
            if (int'(bus.SIN) < mn) mn = int'(bus.SIN);
        end
    endtask

    initial begin
        int mx, mn, guard, dph, amp;
        bit c, w;
        rst_n = 1'b0;
        bus.ce = 1'b1; bus.we = 1'b1; bus.AMP = 12'd777; bus.DPH = 16'h1234;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_SIN", int'(bus.SIN), 4096);
        check("rst_AMP_R", int'(bus.AMP_R), 0);
        check("rst_ce_tact", int'(bus.ce_tact), 0);
        check("rst_ce_zero", int'(bus.ce_zero), 0);
        bus.ce = 1'b0; bus.we = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int j = 0; j < 6; j++) tick(1'b1, 1'b0, 0, 0);
        check("idle_SIN", int'(bus.SIN), 4096);

        run_plan();

        // full-scale amplitude, loaded at the next period boundary
        for (int j = 0; j < 64; j++) tick(1'b1, 1'b1, 4095, 'h400);
        track(70, mx, mn);
        check("full_peak", mx, 8191);
        check("full_trough", mn, 1);

        // mid-period load request must be ignored until the wrap
        guard = 0;
        while (m_ph != 32768 && guard < 64) begin
            tick(1'b1, 1'b0, 0, 0);
            guard++;
        end
        for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 500, 'h400);
        check("mid_amp_hold", int'(bus.AMP_R), 4095);
        for (int j = 0; j < 40; j++) tick(1'b1, 1'b1, 500, 'h400);
        track(70, mx, mn);
        check("amp500_AMP_R", int'(bus.AMP_R), 500);
        check("amp500_peak", mx, 4596);
        check("amp500_trough", mn, 3596);

        // ce one-in-three with garbage on the idle ticks
        for (int j = 0; j < 240; j++) begin
            c = (j % 3 == 0);
            w = c ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
            tick(c, w, $urandom_range(0, 4095), $urandom_range(0, 1) ? 'h400 : 'h800);
        end

        // random operation across the step/amplitude range
        for (int j = 0; j < 600; j++) begin
            case ($urandom_range(0, 4))
                0: dph = 0;
                1: dph = 'h400;
                2: dph = $urandom_range(1, 255);
                3: dph = $urandom_range('h8000, 'hFFFF);
                default: dph = $urandom_range(1, 65535);
            endcase
            case ($urandom_range(0, 3))
                0: amp = 0;
                1: amp = 4095;
                default: amp = $urandom_range(0, 4095);
            endcase
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, amp, dph);
        end

        // asynchronous reset mid-period, then the reference waveform again
        tick(1'b1, 1'b1, 1000, 'h400);
        for (int j = 0; j < 64; j++) tick(1'b1, 1'b1, 1000, 'h400);
        for (int j = 0; j < 20; j++) tick(1'b1, 1'b0, 0, 0);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_SIN", int'(bus.SIN), 4096);
        check("arst_AMP_R", int'(bus.AMP_R), 0);
        check("arst_ce_zero", int'(bus.ce_zero), 0);
        check("arst_ce_tact", int'(bus.ce_tact), 0);
        bus.ce = 1'b0; bus.we = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_plan();

        tick(1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 0, 0);
        check("q_out_drained", q_out.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
